// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, FSM states,
// ALU operations and datapath mux select codes.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_ADDI  = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_JUMP  = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam logic [1:0] PC_SRC_ALU  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MDR = 1'b1;

endpackage

// File: rtl/cpu_alu_op_dec.sv
// Opcode classifier: ALU operation for the EXEC step plus R-type and illegal flags.
module cpu_alu_op_dec
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       is_rtype,
    output logic       is_illegal
);

    // BEQ compares by subtraction; every address/immediate form adds.
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_BEQ:  alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign is_rtype   = (opcode <= OP_OR);
    assign is_illegal = (opcode > OP_JUMP) && (opcode != OP_HALT);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback,
// drives all datapath strobes (Mealy), owns the memory handshake and retire counter.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         opcode,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               wb_sel,
    output logic [2:0]         state,
    output logic               halted,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count
);

    logic [2:0] next_state;
    logic [2:0] dec_alu_op;
    logic       is_rtype;
    logic       is_illegal;
    logic       retire;
    logic       set_illegal;

    cpu_alu_op_dec u_dec (
        .opcode     (opcode),
        .alu_op     (dec_alu_op),
        .is_rtype   (is_rtype),
        .is_illegal (is_illegal)
    );

    always_comb begin
        next_state  = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op      = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        wb_sel      = WB_ALU;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_ONE;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            // Branch target is precomputed here regardless of opcode.
            ST_DECODE: begin
                alu_src_b = SRCB_IMM;
                if (opcode == OP_HALT) begin
                    next_state = ST_HALT;
                end else if (is_illegal) begin
                    next_state  = ST_HALT;
                    set_illegal = 1'b1;
                end else if (opcode == OP_JUMP) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    retire     = 1'b1;
                    next_state = ST_FETCH;
                end else begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                if (is_rtype) begin
                    alu_src_b  = SRCB_REG;
                    next_state = ST_WB;
                end else begin
                    case (opcode)
                        OP_ADDI: begin
                            alu_src_b  = SRCB_IMM;
                            next_state = ST_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_b  = SRCB_IMM;
                            next_state = ST_MEM;
                        end
                        OP_BEQ: begin
                            alu_src_b  = SRCB_REG;
                            pc_write   = alu_zero;
                            pc_src     = PC_SRC_BR;
                            retire     = 1'b1;
                            next_state = ST_FETCH;
                        end
                        default: next_state = ST_FETCH;
                    endcase
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        ir_write   = 1'b1;
                        next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                wb_sel     = (opcode == OP_LOAD) ? WB_MDR : WB_ALU;
                retire     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_IDLE;
        endcase
    end

    assign halted = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (set_illegal) illegal_op <= 1'b1;
            if (retire) instr_count <= instr_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized bench for cpu_ctrl_fsm: instruction-level phase model predicts
// per-cycle state, strobes, retire count and sticky illegal flag.
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    localparam int CW = 8;
    localparam int P_I = 0, P_F = 1, P_D = 2, P_E = 3, P_M = 4, P_W = 5, P_H = 6;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       wb_sel;
        logic       halted;
    } strb_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    opcode = 4'd0;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op;
    logic          reg_write, reg_dst, wb_sel;
    logic [2:0]    state;
    logic          halted, illegal_op;
    logic [CW-1:0] instr_count;
    strb_t         got;

    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    bit model_ill = 1'b0;

    cpu_ctrl_fsm #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .state(state), .halted(halted),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign got = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, wb_sel, halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected strobes for one cycle of an instruction phase, written from the
    // opcode table; m marks the fields whose value matters in that phase.
    task automatic model(input int ph, input int op, input bit z, input bit rdy,
                         output strb_t e, output strb_t m, output logic [2:0] es);
        e = '0;
        m = '0;
        m.mem_req = 1'b1; m.mem_we = 1'b1; m.ir_write = 1'b1;
        m.pc_write = 1'b1; m.reg_write = 1'b1; m.halted = 1'b1;
        es = ST_IDLE;
        case (ph)
            P_F: begin
                es = ST_FETCH;
                m.addr_sel = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
                e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 3'd0;
                if (rdy) begin
                    e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd0; m.pc_src = 2'b11;
                end
            end
            P_D: begin
                es = ST_DECODE;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
                e.alu_src_b = 2'd2; e.alu_op = 3'd0;
                if (op == 8) begin
                    e.pc_write = 1'b1; e.pc_src = 2'd2; m.pc_src = 2'b11;
                end
            end
            P_E: begin
                es = ST_EXEC;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
                e.alu_src_a = 1'b1;
                if (op <= 3) begin
                    e.alu_src_b = 2'd0; e.alu_op = 3'(op);
                end else if (op == 7) begin
                    e.alu_src_b = 2'd0; e.alu_op = 3'd1;
                    e.pc_write = z; e.pc_src = 2'd1; m.pc_src = 2'b11;
                end else begin
                    e.alu_src_b = 2'd2; e.alu_op = 3'd0;
                end
            end
            P_M: begin
                es = ST_MEM;
                m.addr_sel = 1'b1;
                e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (op == 6);
                e.ir_write = rdy && (op == 5);
            end
            P_W: begin
                es = ST_WB;
                m.reg_dst = 1'b1; m.wb_sel = 1'b1;
                e.reg_write = 1'b1; e.reg_dst = (op <= 3); e.wb_sel = (op == 5);
            end
            P_H: begin
                es = ST_HALT;
                e.halted = 1'b1;
            end
            default: es = ST_IDLE;
        endcase
    endtask

    task automatic cyc(input int ph, input int op, input bit z, input bit rdy, input bit st);
        strb_t e, m;
        logic [2:0] es;
        opcode = 4'(op);
        alu_zero = z;
        mem_ready = rdy;
        start = st;
        model(ph, op, z, rdy, e, m, es);
        @(negedge clk);
        chk($sformatf("state ph%0d op%0d", ph, op), 32'(state), 32'(es));
        chk($sformatf("strobes ph%0d op%0d", ph, op), 32'(got & m), 32'(e & m));
        chk("instr_count", 32'(instr_count), 32'(model_cnt));
        chk("illegal_op", 32'(illegal_op), 32'(model_ill));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
        #3;
        model_cnt = 0;
        model_ill = 1'b0;
        chk("reset state", 32'(state), 32'(ST_IDLE));
        chk("reset strobes", 32'(got), 32'd0);
        chk("reset count", 32'(instr_count), 32'd0);
        chk("reset illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        for (int i = 0; i < 2; i++) cyc(P_I, 0, 1'b0, bit'($urandom_range(0, 1)), 1'b0);
        cyc(P_I, 0, 1'b0, bit'($urandom_range(0, 1)), 1'b1);
    endtask

    // fw/mw < 0 pick random wait counts; zsel > 1 picks a random alu_zero.
    task automatic run_instr(input int op, input int fw, input int mw, input int zsel);
        int ph[$];
        int w;
        bit z;
        bit halts;
        halts = (op >= 9);
        ph = '{P_F, P_D};
        if (!halts && op != 8) ph.push_back(P_E);
        if (op == 5 || op == 6) ph.push_back(P_M);
        if (op <= 5) ph.push_back(P_W);
        foreach (ph[i]) begin
            w = 0;
            if (ph[i] == P_F) w = (fw < 0) ? $urandom_range(0, 2) : fw;
            if (ph[i] == P_M) w = (mw < 0) ? $urandom_range(0, 2) : mw;
            for (int k = 0; k < w; k++)
                cyc(ph[i], op, bit'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 1)));
            z = (zsel > 1) ? bit'($urandom_range(0, 1)) : bit'(zsel);
            if (ph[i] == P_F || ph[i] == P_M)
                cyc(ph[i], op, z, 1'b1, bit'($urandom_range(0, 1)));
            else
                cyc(ph[i], op, z, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        if (halts && op != 15) model_ill = 1'b1;
        if (!halts) model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    initial begin
        do_reset();
        go();
        run_instr(0, 0, 0, 0);
        run_instr(5, 0, 3, 0);
        run_instr(7, 0, 0, 1);
        run_instr(7, 0, 0, 0);
        run_instr(8, 0, 0, 0);
        run_instr(6, 1, 2, 0);
        for (int i = 0; i < 300; i++) run_instr($urandom_range(0, 8), -1, -1, 2);

        do_reset();
        go();
        run_instr(11, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(P_H, 11, 1'b0, bit'($urandom_range(0, 1)), 1'b1);

        for (int op = 9; op <= 14; op++) begin
            do_reset();
            go();
            run_instr(op, -1, -1, 2);
            cyc(P_H, op, 1'b0, 1'b1, 1'b1);
        end

        do_reset();
        go();
        for (int i = 0; i < 5; i++) run_instr($urandom_range(0, 8), -1, -1, 2);
        run_instr(15, -1, -1, 2);
        for (int i = 0; i < 3; i++) cyc(P_H, 15, 1'b0, bit'($urandom_range(0, 1)), 1'b1);

        // Reset arriving while a store is waiting on memory.
        do_reset();
        go();
        run_instr(0, 0, 0, 0);
        run_instr(4, 0, 0, 0);
        cyc(P_F, 6, 1'b0, 1'b1, 1'b0);
        cyc(P_D, 6, 1'b0, 1'b0, 1'b0);
        cyc(P_E, 6, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("mem_req before reset", 32'(mem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        model_ill = 1'b0;
        chk("mem_req async drop", 32'(mem_req), 32'd0);
        chk("state async reset", 32'(state), 32'(ST_IDLE));
        chk("count async reset", 32'(instr_count), 32'd0);
        chk("strobes async reset", 32'(got), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cyc(P_I, 6, 1'b0, bit'($urandom_range(0, 1)), 1'b0);
        cyc(P_I, 6, 1'b0, 1'b0, 1'b1);
        cyc(P_F, 6, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
